// File: rtl/fp_pkg.sv
// Shared FP29i / FP16 format constants, pipeline stage records and rounding helper
// for the FP ALU output path.
package fp_pkg;

  localparam int FP29_EXP  = 6;
  localparam int FP29_MAN  = 22;
  localparam int FP29_BIAS = 31;

  localparam int FP16_EXP  = 5;
  localparam int FP16_FRAC = 10;
  localparam int FP16_BIAS = 15;

  localparam logic [15:0] FP16_INF  = 16'h7C00;
  localparam logic [15:0] FP16_ZERO = 16'h0000;

  localparam logic [7:0]        FP16_EXP_MAX = 8'((1 << FP16_EXP) - 1);
  localparam logic signed [7:0] EXP_REBIAS   = 8'(FP29_BIAS - FP16_BIAS);

  // Stage 1: raw operand plus its leading-zero count
  typedef struct packed {
    logic                sgn;
    logic [FP29_EXP-1:0] expn;
    logic [FP29_MAN-1:0] man;
    logic [4:0]          lz;
    logic                zero;
  } s1_t;

  // Stage 2: biased FP16 exponent and working mantissa below the hidden bit
  typedef struct packed {
    logic        sgn;
    logic        zero;
    logic [7:0]  e_field;
    logic [20:0] man;
    logic        sticky;
  } s2_t;

  function automatic logic rne_up(input logic lsb, input logic guard, input logic sticky);
    return guard & (sticky | lsb);
  endfunction

endpackage

// File: rtl/lzc22.sv
// Combinational 22-bit leading-zero counter; all-zero input yields 22.
module lzc22
  import fp_pkg::*;
(
  input  logic [FP29_MAN-1:0] din,
  output logic [4:0]          lz
);

  // Scan upward so the highest set bit determines the count
  always_comb begin
    lz = 5'd22;
    for (int i = 0; i < FP29_MAN; i++) begin
      lz = din[i] ? 5'(FP29_MAN - 1 - i) : lz;
    end
  end

endmodule

// File: rtl/fp29i_to_fp16_pack.sv
// FP29i -> IEEE FP16 packer with round-to-nearest-even, three-stage stallable
// pipeline and sticky overflow/underflow flags.
module fp29i_to_fp16_pack
  import fp_pkg::*;
#(
  parameter int PIPE_DEPTH = 3
)
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sgn,
  input  logic [FP29_EXP-1:0] in_exp,
  input  logic [FP29_MAN-1:0] in_man_dn,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [15:0]         out_fp16,
  input  logic                flag_clr,
  output logic                flag_ovf,
  output logic                flag_unf
);

  if (PIPE_DEPTH != 3) begin : g_bad_depth
    $error("fp29i_to_fp16_pack: PIPE_DEPTH must be 3");
  end

  logic                advance_s;
  logic [4:0]          lz_s;
  s1_t                 s1_r;
  s2_t                 s2_r;
  s2_t                 s2_s;
  logic                s1_valid_r;
  logic                s2_valid_r;
  logic [FP29_MAN-1:0] man_n_s;
  logic signed [7:0]   e16_s;
  logic signed [7:0]   neg_e_s;
  logic [4:0]          shm1_s;
  logic [44:0]         wide_s;
  logic [FP16_FRAC-1:0] frac_s;
  logic                guard_s;
  logic                sticky_s;
  logic                rup_s;
  logic [17:0]         mag_s;
  logic [15:0]         res_s;
  logic                ovf_s;
  logic                unf_s;

  assign advance_s = ~out_valid | out_ready;
  assign in_ready  = advance_s;

  lzc22 u_lzc (
    .din (in_man_dn),
    .lz  (lz_s)
  );

  // Normalise and derive the FP16 exponent; subnormals shift right by 1-e16 (cap 24).
  // The shifter works with shift-1 so the 45-bit window holds every meaningful bit.
  always_comb begin
    man_n_s = s1_r.man << s1_r.lz;
    e16_s   = $signed({2'b00, s1_r.expn}) - $signed({3'b000, s1_r.lz}) - EXP_REBIAS;
    neg_e_s = 8'sd0 - e16_s;
    shm1_s  = 5'd0;
    wide_s  = 45'd0;
    s2_s    = '0;
    s2_s.sgn  = s1_r.sgn;
    s2_s.zero = s1_r.zero;
    if (e16_s > 8'sd0) begin
      s2_s.e_field = e16_s;
      s2_s.man     = man_n_s[20:0];
      s2_s.sticky  = 1'b0;
    end else begin
      if (neg_e_s > 8'sd23) begin
        shm1_s = 5'd23;
      end else begin
        shm1_s = neg_e_s[4:0];
      end
      wide_s       = {man_n_s, 23'd0} >> shm1_s;
      s2_s.e_field = 8'd0;
      s2_s.man     = wide_s[44:24];
      s2_s.sticky  = |wide_s[23:0];
    end
  end

  // Round and pack; a fraction carry ripples into the exponent field naturally
  always_comb begin
    frac_s   = s2_r.man[20:11];
    guard_s  = s2_r.man[10];
    sticky_s = (|s2_r.man[9:0]) | s2_r.sticky;
    rup_s    = rne_up(frac_s[0], guard_s, sticky_s);
    mag_s    = {s2_r.e_field, frac_s} + {17'd0, rup_s};
    res_s    = FP16_ZERO;
    ovf_s    = 1'b0;
    unf_s    = 1'b0;
    if (s2_r.zero) begin
      res_s = FP16_ZERO | {s2_r.sgn, 15'd0};
    end else if (mag_s[17:10] >= FP16_EXP_MAX) begin
      res_s = FP16_INF | {s2_r.sgn, 15'd0};
      ovf_s = 1'b1;
    end else begin
      res_s = {s2_r.sgn, mag_s[14:0]};
      unf_s = (mag_s[14:0] == 15'd0);
    end
  end

  // Pipeline data registers, not reset
  always_ff @(posedge clk) begin
    if (advance_s) begin
      s1_r <= '{sgn: in_sgn, expn: in_exp, man: in_man_dn, lz: lz_s,
                zero: (in_man_dn == 22'd0)};
      s2_r <= s2_s;
    end
  end

  // Valid bits, output word and sticky flags; a flag set beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
      out_valid  <= 1'b0;
      out_fp16   <= FP16_ZERO;
      flag_ovf   <= 1'b0;
      flag_unf   <= 1'b0;
    end else begin
      if (advance_s) begin
        s1_valid_r <= in_valid;
        s2_valid_r <= s1_valid_r;
        out_valid  <= s2_valid_r;
      end
      if (advance_s && s2_valid_r) begin
        out_fp16 <= res_s;
      end
      flag_ovf <= (advance_s & s2_valid_r & ovf_s) | (flag_ovf & ~flag_clr);
      flag_unf <= (advance_s & s2_valid_r & unf_s) | (flag_unf & ~flag_clr);
    end
  end

endmodule

// File: doc/fp29i_to_fp16_pack.md
# fp29i_to_fp16_pack

Output packer that sits directly downstream of the FP ALU. Converts the ALU's FP29i result (sign, 6-bit exponent, 22-bit left-aligned and possibly unnormalised mantissa) into an IEEE FP16 word with round-to-nearest-even. Delivers the word to the FIR output interface over a valid/ready handshake. Keeps sticky overflow/underflow flags for the FIR controller.

## Interface
Parameters:
- `PIPE_DEPTH`, default 3: number of register stages. Fixed at 3; any other value is a synthesis error.

Ports:
- `clk` input 1: single clock. All state changes on its rising edge.
- `rst` input 1: one clock; reset is synchronous and active-high.
- `in_valid` input 1: FP29i operand present.
- `in_ready` output 1: block can accept an operand this cycle.
- `in_sgn` input 1: sign.
- `in_exp` input 6: biased exponent, bias 31.
- `in_man_dn` input 22: mantissa. Bit 21 has weight 2^0. Value = (-1)^s · M·2^-21 · 2^(exp-31).
- `out_valid` output 1: FP16 word present.
- `out_ready` input 1: consumer accepts the word.
- `out_fp16` output 16: IEEE FP16 result.
- `flag_clr` input 1: clears the sticky flags.
- `flag_ovf` output 1: sticky. Set when a result saturated to infinity.
- `flag_unf` output 1: sticky. Set when a nonzero input rounded to ±0.

## Operation
- Stage 1, leading-zero count:
  - lz = leading zeros of `in_man_dn`, range 0..22.
  - zero = (`in_man_dn` == 0).
  - Register sign, exp, man, lz, zero.
- Stage 2, normalise and compute the exponent:
  - man_n = man << lz, 22 bits.
  - e16 = exp − lz − 16, signed 8-bit arithmetic. No wrap is possible in 8 bits.
  - If e16 ≤ 0, the result is subnormal: right-shift man_n by (1 − e16), capped at 24, with a sticky OR of the bits shifted out. Set e_field = 0.
  - Otherwise e_field = e16.
- Stage 3, round and pack:
  - frac = bits [20:11] of the working mantissa (for a subnormal, bit 21 is included after the shift).
  - guard = bit 10. sticky = OR of bits [9:0] and the shift sticky.
  - Round up when guard & (sticky | frac[0]).
  - Carry out of frac increments e_field. A subnormal that rounds up to 0x400 becomes the minimum normal.
  - If e_field ≥ 31 after rounding, output ±inf (0x7C00 / 0xFC00) and set `flag_ovf`.
  - zero input gives ±0, sign preserved, and no flag.
  - A nonzero input that produces magnitude 0 sets `flag_unf`.
- NaN is never produced. The ALU has no NaN encoding.
- Flags:
  - `flag_clr` and a flag set in the same cycle: the set wins.
  - Flags are updated only when the flagged result leaves stage 3 into the output register.

## Timing
- Latency: 3 cycles from input accept to `out_valid`, given `out_ready` held high.
- Throughput: 1 result per cycle.
- Pipeline is a stallable shift:
  - advance = ~`out_valid` | `out_ready`.
  - `in_ready` = advance, combinational.
  - Each stage's valid bit moves forward only on advance. Bubbles propagate as invalid stages and are not compressed.
- Transfer occurs when valid & ready are both high in the same cycle.
  - `out_fp16` holds stable while `out_valid` & ~`out_ready`.
  - Simultaneous output pop and input push are allowed.
- Reset values:
  - All valid bits 0, so `out_valid` = 0 and `in_ready` = 1 one cycle after reset.
  - `out_fp16` = 0x0000, `flag_ovf` = 0, `flag_unf` = 0.
- Reset mid-operation discards all in-flight results. No partial output appears.
- Data registers are not reset except `out_fp16`. Only valid bits and flags need reset.

## Structure
- Shared package `fp_pkg`:
  - FP29i widths: EXP = 6, MAN = 22, bias 31.
  - FP16 widths: EXP = 5, FRAC = 10, bias 15.
  - Constants FP16_INF = 0x7C00 and FP16_ZERO = 0x0000.
- Sub-module `lzc22`: combinational 22-bit leading-zero counter with a 5-bit output. It is reused later by the accumulator normaliser.
- Expected RTL size: about 200 lines.

## Test plan
- Normalised input: exp=31, man=0x200000 → 0x3C00.
- Unnormalised input: exp=32, man=0x100000 (lz=1) → 0x3C00. Same input with sgn=1 → 0xBC00.
- Rounding:
  - man=0x200400, exp=31 (exact tie, frac even) → 0x3C00.
  - man=0x200C00 (tie, frac odd) → 0x3C02.
  - man=0x3FFFFF, exp=31 → 0x4000 (carry into the exponent).
- Range limits:
  - exp=63, man=0x200000 → 0x7C00, `flag_ovf`=1.
  - exp=7, man=0x200000 → 0x0001.
  - exp=6, man=0x200000 (tie to even) → 0x0000, `flag_unf`=1.
  - man=0 → 0x0000, no flag.
  - `flag_clr` pulse → both flags 0.
- Backpressure:
  - Stream 8 back-to-back inputs with `out_ready` toggling randomly.
  - Required: all 8 outputs in order, no loss or duplication, `out_fp16` stable while stalled.
  - Required: `in_ready` low exactly in cycles where `out_valid` & ~`out_ready`.
- Reset mid-stream: assert `rst` with 3 results in flight → next cycle `out_valid`=0, flags 0. The first post-reset input emerges after 3 cycles.
